// File: rtl/cirno9_tohost_dev_if.sv
// cirno9 data-bus request/response channel between a core-side initiator and the tohost device.
// Both channels: a beat transfers on the rising edge where valid & ready are both high; the sender
// holds valid and its payload stable until that edge, and ready is allowed to depend on valid.
`timescale 1ns/1ps
interface cirno9_tohost_dev_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/cirno9_tohost_dev.sv
// cirno9 test-harness host device: TOHOST/FROMHOST, byte console FIFO, STATUS, CYCLE/INSTRET.
// Define TOHOST_PERF_EN to build the 64-bit counters; without it offsets 0x10-0x1C read as 0.
`timescale 1ns/1ps
module cirno9_tohost_dev #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cirno9_tohost_dev_if.slave        bus,
    input  logic                      retire_i,
    output logic                      con_valid,
    input  logic                      con_ready,
    output logic [7:0]                con_data,
    output logic                      done,
    output logic                      pass,
    output logic [30:0]               exit_code
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] REG_TOHOST   = 3'd0;
    localparam logic [2:0] REG_FROMHOST = 3'd1;
    localparam logic [2:0] REG_CONSOLE  = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_CYC_LO   = 3'd4;
    localparam logic [2:0] REG_CYC_HI   = 3'd5;
    localparam logic [2:0] REG_INS_LO   = 3'd6;
    localparam logic [2:0] REG_INS_HI   = 3'd7;

    logic [2:0]  reg_sel;
    logic        misaligned;
    logic        cmd_err;
    logic        accept;
    logic        wr_ok;
    logic        rd_ok;
    logic        console_wr;

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [31:0] tohost_q;
    logic [31:0] fromhost_q;
    logic [31:0] merged_to;
    logic [31:0] merged_from;
    logic        done_q;
    logic [30:0] exit_q;

    logic [31:0] status_word;
    logic [31:0] perf_rdata;
    logic [31:0] rd_data;

    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) v[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return v;
    endfunction

    // Request decode; errors are decided purely from address and direction
    assign reg_sel    = bus.cmd_addr[4:2];
    assign misaligned = (bus.cmd_addr[1:0] != 2'b00);
    assign cmd_err    = misaligned
                      | (!bus.cmd_read && (reg_sel >= REG_STATUS))
                      | ( bus.cmd_read && (reg_sel == REG_CONSOLE));
    assign console_wr = bus.cmd_valid & !bus.cmd_read & (bus.cmd_addr == 5'h08);

    // A full FIFO blocks CONSOLE writes; a same-cycle pop only frees space for the next cycle
    assign bus.cmd_ready = (!rsp_valid_q | bus.rsp_ready) & !(console_wr & fifo_full);

    assign accept = bus.cmd_valid & bus.cmd_ready;
    assign wr_ok  = accept & !bus.cmd_read & !cmd_err;
    assign rd_ok  = accept &  bus.cmd_read & !cmd_err;

    assign merged_to   = merge_bytes(tohost_q,   bus.cmd_wdata, bus.cmd_wmask);
    assign merged_from = merge_bytes(fromhost_q, bus.cmd_wdata, bus.cmd_wmask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tohost_q   <= '0;
            fromhost_q <= '0;
            done_q     <= 1'b0;
            exit_q     <= '0;
        end else if (wr_ok) begin
            if (reg_sel == REG_TOHOST) begin
                tohost_q <= merged_to;
                if (!done_q && merged_to[0]) begin
                    done_q <= 1'b1;
                    exit_q <= merged_to[31:1];
                end
            end
            if (reg_sel == REG_FROMHOST) fromhost_q <= merged_from;
        end
    end

    assign done      = done_q;
    assign exit_code = exit_q;
    assign pass      = done_q & (exit_q == '0);

    // Console FIFO: pointers carry one extra wrap bit so full and empty are distinguishable
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign push       = wr_ok & (reg_sel == REG_CONSOLE) & bus.cmd_wmask[0];
    assign pop        = con_valid & con_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= bus.cmd_wdata[7:0];
    end

    assign con_valid = !fifo_empty;
    assign con_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q[AW-1:0]];

    assign status_word = {16'h0000, 8'(fifo_count), 6'b000000, pass, done_q};

`ifdef TOHOST_PERF_EN
    logic [63:0] cycle_q;
    logic [63:0] instret_q;
    logic [31:0] cycle_hi_snap_q;
    logic [31:0] instret_hi_snap_q;

    // Counters stop once done is set; reading a lo word freezes its hi word for the next hi read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q           <= '0;
            instret_q         <= '0;
            cycle_hi_snap_q   <= '0;
            instret_hi_snap_q <= '0;
        end else begin
            if (!done_q)             cycle_q   <= cycle_q + 64'd1;
            if (!done_q && retire_i) instret_q <= instret_q + 64'd1;
            if (rd_ok && (reg_sel == REG_CYC_LO)) cycle_hi_snap_q   <= cycle_q[63:32];
            if (rd_ok && (reg_sel == REG_INS_LO)) instret_hi_snap_q <= instret_q[63:32];
        end
    end

    always_comb begin
        perf_rdata = '0;
        case (reg_sel)
            REG_CYC_LO: perf_rdata = cycle_q[31:0];
            REG_CYC_HI: perf_rdata = cycle_hi_snap_q;
            REG_INS_LO: perf_rdata = instret_q[31:0];
            REG_INS_HI: perf_rdata = instret_hi_snap_q;
            default:    perf_rdata = '0;
        endcase
    end
`else
    logic unused_retire;
    assign unused_retire = retire_i;
    assign perf_rdata    = '0;
`endif

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_TOHOST:   rd_data = tohost_q;
            REG_FROMHOST: rd_data = fromhost_q;
            REG_CONSOLE:  rd_data = '0;
            REG_STATUS:   rd_data = status_word;
            default:      rd_data = perf_rdata;
        endcase
    end

    // Registered response; errored and write responses always carry zero data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= cmd_err;
            rsp_rdata_q <= rd_ok ? rd_data : 32'h0;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_cirno9_tohost_dev.sv
// Self-checking bench for cirno9_tohost_dev: register-map vector table, console/done/hold
// sequences, and a randomized run against a queue-based transaction model.
`timescale 1ns/1ps
module tb_cirno9_tohost_dev;
    localparam int DEPTH = 8;
`ifdef TOHOST_PERF_EN
    localparam int RND_MAX_WORD = 3;
`else
    localparam int RND_MAX_WORD = 7;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        retire_i = 1'b0;
    logic        con_ready = 1'b0;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        done;
    logic        pass;
    logic [30:0] exit_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    cirno9_tohost_dev_if bus();

    cirno9_tohost_dev #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .retire_i  (retire_i),
        .con_valid (con_valid),
        .con_ready (con_ready),
        .con_data  (con_data),
        .done      (done),
        .pass      (pass),
        .exit_code (exit_code)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.cmd_valid = 1'b0;
        bus.cmd_read  = 1'b0;
        bus.cmd_addr  = 5'h00;
        bus.cmd_wdata = 32'h0;
        bus.cmd_wmask = 4'h0;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus_idle();
        con_ready = 1'b0;
        retire_i  = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chkb({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        chkb({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
        chkb({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
        chkb({tag, "_con_valid"}, con_valid, 1'b0);
        check({tag, "_con_data"}, 32'(con_data), 32'h0);
        chkb({tag, "_done"}, done, 1'b0);
        chkb({tag, "_pass"}, pass, 1'b0);
        check({tag, "_exit_code"}, 32'(exit_code), 32'h0);
    endtask

    // Called at a falling edge; returns at the falling edge where the response is first visible
    task automatic do_txn(input logic rd, input logic [4:0] a, input logic [31:0] wd,
                          input logic [3:0] wm, output logic [31:0] rdata, output logic err);
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = rd;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        bus.cmd_wmask = wm;
        bus.rsp_ready = 1'b1;
        #1;
        for (n = 0; n < 50 && !bus.cmd_ready; n++) begin
            @(negedge clk);
            #1;
        end
        rdata = 32'hDEAD_BEEF;
        err   = 1'bx;
        if (!bus.cmd_ready) begin
            chkb("txn_accept_timeout", bus.cmd_ready, 1'b1);
            bus_idle();
            return;
        end
        @(posedge clk);
        @(negedge clk);
        chkb("txn_rsp_latency", bus.rsp_valid, 1'b1);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.cmd_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic rd, input logic [4:0] a, input logic [31:0] wd,
                                input logic [3:0] wm, input logic [31:0] er, input logic ee);
        vec_t v;
        v.rd = rd; v.addr = a; v.wdata = wd; v.wmask = wm; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Transaction-level model: registers, a byte queue for the console and one pending response
    task automatic run_random(input int ncyc);
        logic [31:0] m_to, m_from, m_rdata, v, r_data;
        logic [30:0] m_exit;
        logic [7:0]  m_fifo[$];
        logic        m_done, m_pend, m_err, exp_ready, fire, pop_now, held, r_err, m_pass;
        logic [2:0]  w;
        logic [4:0]  a;
        m_to = 0; m_from = 0; m_exit = 0; m_done = 0; m_pend = 0; m_err = 0; m_rdata = 0;
        held = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (!held) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.cmd_valid = 1'b0;
                end else begin
                    case ($urandom_range(0, 9))
                        0:          a = {3'($urandom_range(0, 7)), 2'($urandom_range(1, 3))};
                        1, 2, 3, 4: a = 5'h08;
                        default:    a = {3'($urandom_range(0, RND_MAX_WORD)), 2'b00};
                    endcase
                    bus.cmd_valid = 1'b1;
                    bus.cmd_read  = 1'($urandom_range(0, 1));
                    bus.cmd_addr  = a;
                    bus.cmd_wdata = $urandom;
                    bus.cmd_wmask = 4'($urandom_range(0, 15));
                    if (a == 5'h00) bus.cmd_wdata[0] = ($urandom_range(0, 24) == 0);
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            con_ready     = ($urandom_range(0, 2) == 0);
            retire_i      = 1'($urandom_range(0, 1));
            #1;
            m_pass    = m_done && (m_exit == 0);
            exp_ready = (!m_pend || bus.rsp_ready) &&
                        !(bus.cmd_valid && !bus.cmd_read && bus.cmd_addr == 5'h08 &&
                          m_fifo.size() == DEPTH);
            chkb("rnd_cmd_ready", bus.cmd_ready, exp_ready);
            chkb("rnd_rsp_valid", bus.rsp_valid, m_pend);
            if (m_pend) begin
                check("rnd_rsp_rdata", bus.rsp_rdata, m_rdata);
                chkb("rnd_rsp_err", bus.rsp_err, m_err);
            end
            chkb("rnd_con_valid", con_valid, m_fifo.size() != 0);
            if (m_fifo.size() != 0) check("rnd_con_data", 32'(con_data), 32'(m_fifo[0]));
            chkb("rnd_done", done, m_done);
            chkb("rnd_pass", pass, m_pass);
            check("rnd_exit_code", 32'(exit_code), 32'(m_exit));

            fire    = bus.cmd_valid && exp_ready;
            pop_now = con_ready && (m_fifo.size() != 0);
            if (m_pend && bus.rsp_ready) m_pend = 1'b0;
            if (fire) begin
                a = bus.cmd_addr;
                w = a[4:2];
                r_err = (a[1:0] != 2'b00) || (!bus.cmd_read && w >= 3) || (bus.cmd_read && w == 2);
                r_data = 32'h0;
                if (bus.cmd_read && !r_err) begin
                    if (w == 0) r_data = m_to;
                    else if (w == 1) r_data = m_from;
                    else if (w == 3) r_data = {16'h0, 8'(m_fifo.size()), 6'h0, m_pass, m_done};
                end
                if (!bus.cmd_read && !r_err) begin
                    v = (w == 0) ? m_to : m_from;
                    for (int b = 0; b < 4; b++)
                        if (bus.cmd_wmask[b]) v[b*8 +: 8] = bus.cmd_wdata[b*8 +: 8];
                    if (w == 0) begin
                        m_to = v;
                        if (!m_done && v[0]) begin
                            m_done = 1'b1;
                            m_exit = v[31:1];
                        end
                    end else if (w == 1) begin
                        m_from = v;
                    end else if (w == 2 && bus.cmd_wmask[0]) begin
                        m_fifo.push_back(bus.cmd_wdata[7:0]);
                    end
                end
                m_pend  = 1'b1;
                m_rdata = r_data;
                m_err   = r_err;
            end
            if (pop_now) void'(m_fifo.pop_front());
            held = bus.cmd_valid && !fire;
            @(negedge clk);
        end
        bus_idle();
        con_ready = 1'b0;
        retire_i  = 1'b0;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd_v;
        logic        er_v;
        logic [7:0]  got[$];
        logic        acc, acc_now;
        int          cyc;
        logic [63:0] comb1, comb2;
        logic [31:0] lo_v, hi_v;

        bus_idle();

        // Reset state
        apply_reset();
        #1;
        check_reset_outputs("reset");

        // Register map vectors, applied from an idle device
        vecs.push_back(mk(1'b0, 5'h04, 32'h1234_5678, 4'hF, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 5'h04, 32'h0,         4'h0, 32'h1234_5678, 1'b0));
        vecs.push_back(mk(1'b0, 5'h04, 32'hAABB_CCDD, 4'h2, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 5'h04, 32'h0,         4'h0, 32'h1234_CC78, 1'b0));
        vecs.push_back(mk(1'b0, 5'h04, 32'hFF00_FF00, 4'h9, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 5'h04, 32'h0,         4'h0, 32'hFF34_CC00, 1'b0));
        vecs.push_back(mk(1'b0, 5'h00, 32'h0000_0010, 4'hF, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 5'h00, 32'h0,         4'h0, 32'h0000_0010, 1'b0));
        vecs.push_back(mk(1'b1, 5'h0C, 32'h0,         4'h0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 5'h06, 32'h0,         4'h0, 32'h0,         1'b1));
        vecs.push_back(mk(1'b0, 5'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1));
        vecs.push_back(mk(1'b1, 5'h08, 32'h0,         4'h0, 32'h0,         1'b1));
        vecs.push_back(mk(1'b0, 5'h05, 32'h0,         4'hF, 32'h0,         1'b1));
        vecs.push_back(mk(1'b0, 5'h01, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1));
        vecs.push_back(mk(1'b0, 5'h10, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1));
        vecs.push_back(mk(1'b1, 5'h04, 32'h0,         4'h0, 32'hFF34_CC00, 1'b0));
        vecs.push_back(mk(1'b0, 5'h00, 32'h0000_0001, 4'h2, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 5'h00, 32'h0,         4'h0, 32'h0000_0010, 1'b0));
        vecs.push_back(mk(1'b1, 5'h0C, 32'h0,         4'h0, 32'h0,         1'b0));
`ifndef TOHOST_PERF_EN
        vecs.push_back(mk(1'b1, 5'h10, 32'h0,         4'h0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 5'h14, 32'h0,         4'h0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 5'h18, 32'h0,         4'h0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 5'h1C, 32'h0,         4'h0, 32'h0,         1'b0));
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            retire_i = 1'($urandom_range(0, 1));
            do_txn(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rd_v, er_v);
            check($sformatf("vec%0d_rdata", i), rd_v, vecs[i].exp_rdata);
            chkb($sformatf("vec%0d_err", i), er_v, vecs[i].exp_err);
        end
        retire_i = 1'b0;
        chkb("vec_done_clear", done, 1'b0);

        // Console: fill, stall the ninth push, then drain in order
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            do_txn(1'b0, 5'h08, 32'(65 + i), 4'h1, rd_v, er_v);
            chkb("con_push_err", er_v, 1'b0);
        end
        chkb("con_valid_full", con_valid, 1'b1);
        check("con_head", 32'(con_data), 32'h41);
        do_txn(1'b1, 5'h0C, 32'h0, 4'h0, rd_v, er_v);
        check("status_full", rd_v, 32'h0000_0800);
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b0;
        bus.cmd_addr  = 5'h08;
        bus.cmd_wdata = 32'h49;
        bus.cmd_wmask = 4'h1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chkb("con_full_stall", bus.cmd_ready, 1'b0);
            @(negedge clk);
        end
        con_ready = 1'b1;
        #1;
        chkb("pop_no_unblock", bus.cmd_ready, 1'b0);
        acc = 1'b0;
        acc_now = 1'b0;
        cyc = 0;
        while (!(acc && got.size() == 9) && cyc < 40) begin
            if (con_valid) got.push_back(con_data);
            if (bus.cmd_valid && bus.cmd_ready) acc_now = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (acc_now) begin
                bus.cmd_valid = 1'b0;
                acc = 1'b1;
                acc_now = 1'b0;
            end
            #1;
            cyc++;
        end
        chkb("con_ninth_accepted", acc, 1'b1);
        check("con_drain_count", 32'(got.size()), 32'd9);
        for (int i = 0; i < got.size() && i < 9; i++)
            check($sformatf("con_drain%0d", i), 32'(got[i]), 32'(65 + i));
        chkb("con_empty_after", con_valid, 1'b0);
        con_ready = 1'b0;

        // Randomized run against the model
        apply_reset();
        run_random(2500);

        // done/pass with a zero exit code
        apply_reset();
        do_txn(1'b0, 5'h00, 32'h0000_0001, 4'hF, rd_v, er_v);
        chkb("pass_done", done, 1'b1);
        chkb("pass_pass", pass, 1'b1);
        check("pass_exit", 32'(exit_code), 32'h0);
        do_txn(1'b1, 5'h0C, 32'h0, 4'h0, rd_v, er_v);
        check("pass_status", rd_v, 32'h0000_0003);

        // done with a failing exit code that later writes cannot change
        apply_reset();
        do_txn(1'b0, 5'h00, 32'h0000_000B, 4'hF, rd_v, er_v);
        chkb("fail_done", done, 1'b1);
        chkb("fail_pass", pass, 1'b0);
        check("fail_exit", 32'(exit_code), 32'h5);
        do_txn(1'b0, 5'h00, 32'h0000_0001, 4'hF, rd_v, er_v);
        check("fail_exit_sticky", 32'(exit_code), 32'h5);
        chkb("fail_pass_sticky", pass, 1'b0);
        do_txn(1'b1, 5'h00, 32'h0, 4'h0, rd_v, er_v);
        check("fail_tohost_updated", rd_v, 32'h0000_0001);
        do_txn(1'b1, 5'h0C, 32'h0, 4'h0, rd_v, er_v);
        check("fail_status", rd_v, 32'h0000_0001);

        // Response held by backpressure, then reset mid-hold
        apply_reset();
        do_txn(1'b0, 5'h04, 32'hCAFE_F00D, 4'hF, rd_v, er_v);
        do_txn(1'b0, 5'h08, 32'h5A, 4'h1, rd_v, er_v);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b1;
        bus.cmd_addr  = 5'h04;
        bus.rsp_ready = 1'b0;
        #1;
        chkb("hold_accept", bus.cmd_ready, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            chkb("hold_rsp_valid", bus.rsp_valid, 1'b1);
            check("hold_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
            chkb("hold_rsp_err", bus.rsp_err, 1'b0);
            chkb("hold_cmd_ready", bus.cmd_ready, 1'b0);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef TOHOST_PERF_EN
        // INSTRET counts pulses exactly and freezes once done is set
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            retire_i = 1'b1;
            @(negedge clk);
            retire_i = 1'b0;
            @(negedge clk);
        end
        do_txn(1'b1, 5'h18, 32'h0, 4'h0, rd_v, er_v);
        check("instret_lo", rd_v, 32'd10);
        do_txn(1'b1, 5'h1C, 32'h0, 4'h0, rd_v, er_v);
        check("instret_hi", rd_v, 32'd0);
        do_txn(1'b0, 5'h00, 32'h0000_0001, 4'hF, rd_v, er_v);
        for (int i = 0; i < 5; i++) begin
            retire_i = 1'b1;
            @(negedge clk);
            retire_i = 1'b0;
            @(negedge clk);
        end
        do_txn(1'b1, 5'h18, 32'h0, 4'h0, rd_v, er_v);
        check("instret_frozen", rd_v, 32'd10);
        do_txn(1'b1, 5'h10, 32'h0, 4'h0, lo_v, er_v);
        do_txn(1'b1, 5'h10, 32'h0, 4'h0, rd_v, er_v);
        check("cycle_frozen", rd_v, lo_v);

        // CYCLE lo/hi pair stays coherent across the 32-bit carry
        apply_reset();
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.cycle_q;
        @(negedge clk);
        do_txn(1'b1, 5'h10, 32'h0, 4'h0, lo_v, er_v);
        do_txn(1'b1, 5'h14, 32'h0, 4'h0, hi_v, er_v);
        comb1 = {hi_v, lo_v};
        chkb("cycle_pair_coherent", (comb1 >= 64'h0000_0000_FFFF_FFFE) &&
                                    (comb1 <= 64'h0000_0001_0000_0008), 1'b1);
        do_txn(1'b1, 5'h10, 32'h0, 4'h0, lo_v, er_v);
        do_txn(1'b1, 5'h14, 32'h0, 4'h0, hi_v, er_v);
        comb2 = {hi_v, lo_v};
        chkb("cycle_pair_advances", (comb2 > comb1) && (comb2 <= comb1 + 64'd16), 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
